// File: rtl/udp_preimage_scan_pkg.sv
// Shared types and defaults for the truth-table preimage scanner.
package udp_preimage_scan_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // a | (b & ~c), indexed {a,b,c}
    localparam logic [7:0] DEF_TABLE = 8'hF4;
endpackage

// File: rtl/udp_preimage_scan_if.sv
// Request / match-stream bundle for udp_preimage_scan.
interface udp_preimage_scan_if #(parameter int N_IN = 3);
    logic                 start;
    logic                 target;
    logic [2**N_IN-1:0]   tbl_in;
    logic                 use_def;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_IN-1:0]      out_combo;
    logic                 out_last;
    logic                 done;
    logic [N_IN:0]        match_count;

    modport master (
        output start, target, tbl_in, use_def, out_ready,
        input  busy, out_valid, out_combo, out_last, done, match_count
    );
    modport slave (
        input  start, target, tbl_in, use_def, out_ready,
        output busy, out_valid, out_combo, out_last, done, match_count
    );
endinterface

// File: rtl/udp_preimage_lastmask.sv
// Flags whether any table entry above idx also equals the target value.
module udp_preimage_lastmask #(
    parameter int N_IN = 3
) (
    input  logic [2**N_IN-1:0] tbl,
    input  logic               target,
    input  logic [N_IN-1:0]    idx,
    output logic               any_above
);
    logic [2**N_IN-1:0] hit;
    logic [2**N_IN-1:0] above;

    assign hit = target ? tbl : ~tbl;

    for (genvar j = 0; j < 2**N_IN; j++) begin : g_above
        localparam logic [N_IN-1:0] J = N_IN'(j);
        assign above[j] = hit[j] & (J > idx);
    end

    assign any_above = |above;
endmodule

// File: rtl/udp_preimage_scan.sv
// Walks every combination of a latched truth table once and streams the ones
// whose output equals the target, then pulses done with the match count.
module udp_preimage_scan #(
    parameter int                 N_IN      = 3,
    parameter logic [2**N_IN-1:0] DEF_TABLE = udp_preimage_scan_pkg::DEF_TABLE
) (
    input logic               clk,
    input logic               rst,
    udp_preimage_scan_if.slave bus
);
    import udp_preimage_scan_pkg::*;

    localparam logic [N_IN-1:0] IDX_MAX = '1;

    state_t               state, state_nxt;
    logic [N_IN-1:0]      idx;
    logic [2**N_IN-1:0]   tbl;
    logic                 tgt;
    logic                 out_valid_q;
    logic [N_IN-1:0]      out_combo_q;
    logic                 out_last_q;
    logic [N_IN:0]        cnt;
    logic                 match, accept, can_load, advance, any_above;

    assign match    = (tbl[idx] == tgt);
    assign accept   = out_valid_q & bus.out_ready;
    // output slot is free if empty or being drained this cycle
    assign can_load = !out_valid_q || bus.out_ready;
    assign advance  = !match || can_load;

    udp_preimage_lastmask #(.N_IN(N_IN)) u_lastmask (
        .tbl       (tbl),
        .target    (tgt),
        .idx       (idx),
        .any_above (any_above)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SCAN;
            ST_SCAN:  if (advance && idx == IDX_MAX) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!out_valid_q || bus.out_ready) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != ST_IDLE);
        bus.done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            tbl         <= DEF_TABLE;
            tgt         <= 1'b0;
            out_valid_q <= 1'b0;
            out_combo_q <= '0;
            out_last_q  <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    tbl <= bus.use_def ? DEF_TABLE : bus.tbl_in;
                    tgt <= bus.target;
                    cnt <= '0;
                    idx <= '0;
                end
                ST_SCAN: begin
                    if (match && can_load) begin
                        out_combo_q <= idx;
                        out_valid_q <= 1'b1;
                        out_last_q  <= !any_above;
                        cnt         <= cnt + 1'b1;
                    end else if (accept) begin
                        out_valid_q <= 1'b0;
                    end
                    // idx parks on the last entry; the FSM leaves SCAN instead of wrapping
                    if (advance && idx != IDX_MAX) idx <= idx + 1'b1;
                end
                ST_DRAIN: if (accept) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_combo   = out_combo_q;
    assign bus.out_last    = out_last_q;
    assign bus.match_count = cnt;
endmodule
